// File: rtl/prescaled_event_counter.sv
// Tick-driven event counter: a programmable prescaler produces a step pulse that
// advances a binary or BCD counter, up or down, with wrap or saturate at the limits.
module prescaled_event_counter #(
    parameter int DIV_MAX = 24999999,
    parameter int DIGITS  = 2,
    parameter bit BCD     = 1'b0
) (
    input  logic                  CLOCK_50_I,
    input  logic                  RESET_I,
    input  logic                  ENABLE_I,
    input  logic                  UP_I,
    input  logic                  WRAP_I,
    input  logic                  LOAD_I,
    input  logic [4*DIGITS-1:0]   LOAD_VALUE_I,
    output logic [4*DIGITS-1:0]   COUNT_O,
    output logic                  TICK_O,
    output logic                  TC_O
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
    localparam logic [PW-1:0] PRESC_TERM = PW'(DIV_MAX);
    localparam logic [W-1:0]  CNT_MAX    = BCD ? {DIGITS{4'h9}} : {W{1'b1}};

    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  count_q, count_d;
    logic          tick_q, tick_d;
    logic          tc_q, tc_d;

    logic          step;
    logic          at_max;
    logic          at_min;
    logic [W-1:0]  count_inc;
    logic [W-1:0]  count_dec;
    logic          carry;
    logic          borrow;

    assign step   = ENABLE_I && (presc_q == PRESC_TERM);
    assign at_max = (count_q == CNT_MAX);
    assign at_min = (count_q == '0);

    // Non-limit neighbours of the current count; BCD ripples nibble by nibble.
    always_comb begin
        count_inc = count_q;
        count_dec = count_q;
        carry     = 1'b1;
        borrow    = 1'b1;
        if (BCD) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] >= 4'd9) begin
                        count_inc[4*i +: 4] = 4'd0;
                    end else begin
                        count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry               = 1'b0;
                    end
                end
                if (borrow) begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        count_dec[4*i +: 4] = 4'd9;
                    end else begin
                        count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        borrow              = 1'b0;
                    end
                end
            end
        end else begin
            count_inc = count_q + W'(1);
            count_dec = count_q - W'(1);
        end
    end

    // Load beats a coincident step, which is simply dropped.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (LOAD_I) begin
            count_d = LOAD_VALUE_I;
            presc_d = '0;
        end else if (step) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (UP_I) begin
                if (at_max) begin
                    tc_d    = 1'b1;
                    count_d = WRAP_I ? '0 : CNT_MAX;
                end else begin
                    count_d = count_inc;
                end
            end else begin
                if (at_min) begin
                    tc_d    = 1'b1;
                    count_d = WRAP_I ? CNT_MAX : '0;
                end else begin
                    count_d = count_dec;
                end
            end
        end else if (ENABLE_I) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign COUNT_O = count_q;
    assign TICK_O  = tick_q;
    assign TC_O    = tc_q;

endmodule

// File: doc/prescaled_event_counter.md
# prescaled_event_counter

Parametrised tick-driven event counter: a programmable prescaler divides CLOCK_50_I down to a one-cycle step pulse, and a multi-digit counter steps on each pulse. The counter runs in binary or BCD, up or down, and either wraps or saturates. It supports synchronous load and flags carry/borrow. It sits between the board clock and the seven-segment/LED display path, replacing hand-built divider-plus-counter logic in lab tops.

## Interface
- DIV_MAX, 24999999: prescaler terminal value; one step every DIV_MAX+1 enabled cycles; must be ≥1
- DIGITS, 2: number of 4-bit nibbles; counter width W = 4*DIGITS
- BCD, 0: 0 = binary over W bits; 1 = each nibble counts decimal 0–9
- CLOCK_50_I  in  1  sole clock, rising edge
- RESET_I  in  1  reset; synchronous, active-high
- ENABLE_I  in  1  1 = prescaler advances and steps occur; 0 = prescaler and count hold
- UP_I  in  1  1 = count up, 0 = count down; sampled on the step edge
- WRAP_I  in  1  1 = wrap at limit; 0 = saturate at limit
- LOAD_I  in  1  synchronous load request
- LOAD_VALUE_I  in  W  value loaded into count
- COUNT_O  out  W  current count, registered
- TICK_O  out  1  one-cycle pulse, high in the cycle after each step edge
- TC_O  out  1  one-cycle carry/borrow pulse, coincident with TICK_O

## Operation
- Prescaler: register of ceil(log2(DIV_MAX+1)) bits, counting 0..DIV_MAX while ENABLE_I=1.
- Step edge: a clock edge where ENABLE_I=1 and prescaler==DIV_MAX. On this edge the prescaler goes to 0, TICK_O goes to 1, and COUNT_O updates.
- Priority per edge: RESET_I > LOAD_I > step > hold.
- Reset: prescaler=0, COUNT_O=0, TICK_O=0, TC_O=0.
- Load: COUNT_O=LOAD_VALUE_I, prescaler=0, TICK_O=0, TC_O=0. A pending step in the same cycle is discarded. Load works regardless of ENABLE_I.
- Limits: max is 2^W−1 in binary mode and all nibbles =9 in BCD mode. Min is 0 in both modes.
- Step up:
  - If count==max: TC_O=1. WRAP_I=1 gives count 0; WRAP_I=0 holds max.
  - Otherwise: count+1, TC_O=0.
- Step down:
  - If count==0: TC_O=1. WRAP_I=1 gives max; WRAP_I=0 holds 0.
  - Otherwise: count−1, TC_O=0.
- BCD arithmetic is nibble-wise ripple.
  - Up: a nibble ≥9 becomes 0 and carries; otherwise +1, no carry.
  - Down: nibble 0 becomes 9 and borrows; a nibble >9 (only reachable by load) decrements with no borrow.
  - A count containing an invalid nibble is never equal to max.
- Non-step edges: TICK_O=0, TC_O=0, count holds.
- ENABLE_I low: prescaler freezes at its current value; the next step occurs after the remaining enabled cycles.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- First step after reset release with ENABLE_I=1 throughout: edge DIV_MAX+1 counted from the first post-reset edge. TICK_O is high for the cycle that follows.
- Step period: exactly DIV_MAX+1 enabled cycles.
- LOAD_I effect is visible on COUNT_O one cycle after the sampling edge. The next step follows DIV_MAX+1 enabled cycles after the load edge.
- RESET_I asserted mid-period clears everything on that edge. Holding RESET_I high keeps all outputs at their reset values.
- UP_I and WRAP_I are don't-care except on step edges.

## Test plan
- Binary up wrap (DIV_MAX=3, DIGITS=2, BCD=0, UP=1, WRAP=1), run from reset:
  - TICK_O pulses every 4 cycles.
  - COUNT_O goes 0x01, 0x02, …, 0xFF, then 0x00.
  - TC_O=1 only on the 0xFF→0x00 step.
- BCD up saturate (BCD=1, WRAP=0), load 0x98, then 3 steps:
  - COUNT_O goes 0x99, 0x99, 0x99.
  - TC_O=0, 1, 1.
  - Digits never show A–F.
- BCD down wrap (BCD=1, UP=0, WRAP=1), load 0x10, then 3 steps:
  - COUNT_O goes 0x09, 0x08, 0x07.
  - From load 0x00, one step gives 0x99 with TC_O=1.
- ENABLE_I gating (DIV_MAX=3):
  - Drop ENABLE_I for 10 cycles when the prescaler is at 2.
  - COUNT_O and TICK_O stay frozen.
  - The next TICK_O arrives 2 enabled cycles after re-enable.
- Load/step collision: assert LOAD_I=1 with LOAD_VALUE_I=0x42 on a step edge.
  - COUNT_O=0x42, TICK_O=0, TC_O=0.
  - The next step lands DIV_MAX+1 cycles later at 0x43.
- Reset mid-operation: assert RESET_I at count 0x37 with the prescaler at 2.
  - Next cycle: COUNT_O=0x00, TICK_O=0, TC_O=0.
  - After release, the first TICK_O arrives after DIV_MAX+1 cycles.
